clk_mod_phase_ctrl: RTL

//  Sequences the CLK_MOD phase-select BUFGMUX tree: two 2:1 muxes (0/90, 180/270) feeding a final 2:1 mux.

---
 rtl/clk_mod_pkg.sv | 27 ++
 rtl/clk_mod_lock_filter.sv | 41 ++++
 rtl/clk_mod_phase_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/clk_mod_pkg.sv
// Shared phase codes, FSM state encoding and select mapping for the CLK_MOD
// phase-select BUFGMUX tree controller.
package clk_mod_pkg;

    typedef enum logic [1:0] {
        PH_0   = 2'd0,
        PH_90  = 2'd1,
        PH_180 = 2'd2,
        PH_270 = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        IDLE      = 3'd1,
        SW1       = 3'd2,
        SETTLE1   = 3'd3,
        SW2       = 3'd4,
        SETTLE2   = 3'd5,
        DONE      = 3'd6
    } state_t;

    // Bit 0 steers the first-level muxes, bit 1 the final mux.
    function automatic logic [1:0] sel_of(input logic [1:0] phase);
        return {phase[1], phase[0]};
    endfunction

endpackage

// File: rtl/clk_mod_lock_filter.sv
// Two-flop synchroniser for DCM LOCKED followed by a run-length filter:
// locked asserts after LOCK_FILTER consecutive high samples, drops on one low.
module clk_mod_lock_filter #(
    parameter int LOCK_FILTER = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic locked_async,
    output logic locked
);

    localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(LOCK_FILTER);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            run_cnt <= '0;
            locked  <= 1'b0;
        end else begin
            sync_p0 <= locked_async;
            sync_p1 <= sync_p0;
            if (!sync_p1) begin
                run_cnt <= '0;
                locked  <= 1'b0;
            end else begin
                if (run_cnt != RUN_MAX)
                    run_cnt <= run_cnt + CNT_ONE;
                locked <= (run_cnt >= RUN_LAST);
            end
        end
    end

endmodule

// File: rtl/clk_mod_phase_ctrl.sv
// Glitch-safe sequencer for the CLK_MOD phase-select mux tree: changes SEL1 then
// SEL2 with a settle interval after each, only while the DCM is lock-filtered.
// Optional auto-sweep through all four phases under `CLK_MOD_PHASE_SWEEP_EN.
module clk_mod_phase_ctrl
    import clk_mod_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_FILTER   = 4,
`ifdef CLK_MOD_PHASE_SWEEP_EN
    parameter int SWEEP_DWELL   = 1024,
    parameter int DWELL_W       = 16,
`endif
    parameter int CNT_W         = 8
) (
    input  logic       USER_CLOCK,
    input  logic       RESET_N,
    input  logic       DCM_LOCKED,
    input  logic       PHASE_REQ,
    input  logic [1:0] PHASE_TARGET,
`ifdef CLK_MOD_PHASE_SWEEP_EN
    input  logic       SWEEP_EN,
`endif
    output logic       PHASE_ACK,
    output logic       BUSY,
    output logic [1:0] CUR_PHASE,
    output logic       CLK_MOD_PHASE_SEL1,
    output logic       CLK_MOD_PHASE_SEL2
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
`ifdef CLK_MOD_PHASE_SWEEP_EN
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SWEEP_DWELL - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    logic [DWELL_W-1:0] dwell_cnt;
`endif

    state_t           state;
    logic [1:0]       tgt;
    logic [1:0]       tgt_sel;
    logic             pending;
    logic             ack_en;
    logic [CNT_W-1:0] settle_cnt;
    logic             locked;

    clk_mod_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER),
        .CNT_W       (CNT_W)
    ) u_lock_filter (
        .clk          (USER_CLOCK),
        .rst_n        (RESET_N),
        .locked_async (DCM_LOCKED),
        .locked       (locked)
    );

    assign tgt_sel = sel_of(tgt);

    always_ff @(posedge USER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state              <= WAIT_LOCK;
            PHASE_ACK          <= 1'b0;
            BUSY               <= 1'b1;
            CUR_PHASE          <= PH_0;
            CLK_MOD_PHASE_SEL1 <= 1'b0;
            CLK_MOD_PHASE_SEL2 <= 1'b0;
            tgt                <= PH_0;
            pending            <= 1'b0;
            ack_en             <= 1'b0;
            settle_cnt         <= '0;
`ifdef CLK_MOD_PHASE_SWEEP_EN
            dwell_cnt          <= '0;
`endif
        end else begin
            PHASE_ACK <= 1'b0;
`ifdef CLK_MOD_PHASE_SWEEP_EN
            dwell_cnt <= '0;
`endif
            // Lock loss freezes the selects where they are; tgt/pending survive
            // so the interrupted change resumes from SW1 after relock.
            if (state != WAIT_LOCK && !locked) begin
                state      <= WAIT_LOCK;
                BUSY       <= 1'b1;
                settle_cnt <= '0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        if (locked) begin
                            state <= pending ? SW1 : IDLE;
                            BUSY  <= pending;
                        end
                    end
                    IDLE: begin
                        if (PHASE_REQ) begin
                            tgt     <= PHASE_TARGET;
                            pending <= 1'b1;
                            ack_en  <= 1'b1;
                            BUSY    <= 1'b1;
                            state   <= (PHASE_TARGET == CUR_PHASE) ? DONE : SW1;
                        end
`ifdef CLK_MOD_PHASE_SWEEP_EN
                        else if (SWEEP_EN) begin
                            if (dwell_cnt == DWELL_LAST) begin
                                tgt     <= CUR_PHASE + 2'd1;
                                pending <= 1'b1;
                                ack_en  <= 1'b0;
                                BUSY    <= 1'b1;
                                state   <= SW1;
                            end else begin
                                dwell_cnt <= dwell_cnt + DWELL_ONE;
                            end
                        end
`endif
                    end
                    SW1: begin
                        if (CLK_MOD_PHASE_SEL1 != tgt_sel[0]) begin
                            CLK_MOD_PHASE_SEL1 <= tgt_sel[0];
                            settle_cnt         <= '0;
                            state              <= SETTLE1;
                        end else begin
                            state <= SW2;
                        end
                    end
                    SETTLE1: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            state      <= SW2;
                        end else begin
                            settle_cnt <= settle_cnt + CNT_ONE;
                        end
                    end
                    SW2: begin
                        if (CLK_MOD_PHASE_SEL2 != tgt_sel[1]) begin
                            CLK_MOD_PHASE_SEL2 <= tgt_sel[1];
                            settle_cnt         <= '0;
                            state              <= SETTLE2;
                        end else begin
                            state <= DONE;
                        end
                    end
                    SETTLE2: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            state      <= DONE;
                        end else begin
                            settle_cnt <= settle_cnt + CNT_ONE;
                        end
                    end
                    DONE: begin
                        CUR_PHASE <= tgt;
                        PHASE_ACK <= ack_en;
                        pending   <= 1'b0;
                        BUSY      <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= WAIT_LOCK;
                        BUSY  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
